// File: rtl/data_memory_controller.sv
// Data-side access controller: turns level load/store requests from the
// core into valid/ready bus transactions and stalls the PC until done.
module data_memory_controller #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_read,
   input  logic        memory_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_mask,
   output logic [31:0] read_data,
   output logic        write_done,
   output logic        bus_error,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   input  logic        bus_ready,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam int CW =
      TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST =
      CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RESP,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] tmo_cnt;
   logic          req_in;
   logic          tmo_hit;

   assign req_in  = memory_read | memory_write;
   assign tmo_hit = TO_EN && (tmo_cnt == LAST);

   // stall the PC whenever a request is pending and not yet completing
   assign write_done = (state == DONE) |
                       ((state == IDLE) & ~req_in);

   // access sequencer with registered bus payload and completion flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         read_data <= '0;
         bus_error <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wmask <= '0;
      end else begin
         bus_error <= 1'b0;
         unique case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (req_in) begin
                  state     <= REQ;
                  bus_req   <= 1'b1;
                  bus_we    <= memory_write;
                  bus_addr  <= {address[31:2], 2'b00};
                  bus_wdata <= write_data;
                  bus_wmask <= memory_write ? write_mask : 4'b0000;
               end
            end
            REQ: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (bus_ready && bus_we) begin
                  state   <= DONE;
                  bus_req <= 1'b0;
               end else if (tmo_hit) begin
                  state     <= DONE;
                  bus_req   <= 1'b0;
                  bus_error <= 1'b1;
                  if (!bus_we) begin
                     read_data <= '0;
                  end
               end else if (bus_ready) begin
                  state   <= WAIT_RESP;
                  bus_req <= 1'b0;
               end
            end
            WAIT_RESP: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (bus_rvalid) begin
                  state     <= DONE;
                  read_data <= bus_rdata;
               end else if (tmo_hit) begin
                  state     <= DONE;
                  bus_error <= 1'b1;
                  read_data <= '0;
               end
            end
            DONE: begin
               state   <= IDLE;
               tmo_cnt <= '0;
            end
         endcase
      end
   end

endmodule
